collision_scheduler: RTL and testbench

COLLISION_SCHEDULER -- requirements
Module: collision_scheduler

---
 rtl/collision_scheduler_pkg.sv | 11 +
 rtl/collision_scheduler_if.sv | 29 ++
 rtl/collision_scheduler_rect_overlap.sv | 26 ++
 rtl/collision_scheduler.sv | 104 ++++++++++
 tb/tb_collision_scheduler.sv | 158 +++++++++++++++
 5 files changed

// File: rtl/collision_scheduler_pkg.sv
// collision_scheduler_pkg: shared FSM encoding, default box sizes and index-width helper.
package collision_scheduler_pkg;
    typedef enum logic [1:0] {IDLE, FETCH, COMPARE, DONE} state_e;
    localparam int DEF_PLAYER_WIDTH    = 50;
    localparam int DEF_PLAYER_HEIGHT   = 50;
    localparam int DEF_OBSTACLE_WIDTH  = 50;
    localparam int DEF_OBSTACLE_HEIGHT = 50;
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/collision_scheduler_if.sv
// collision_scheduler_if: player/obstacle inputs, position-store select and scan results.
interface collision_scheduler_if
    import collision_scheduler_pkg::*;
#(
    parameter int X_BITWIDTH    = 8,
    parameter int Y_BITWIDTH    = 8,
    parameter int NUM_OBSTACLES = 4
);
    localparam int IDX_W = idx_w(NUM_OBSTACLES);
    logic                     update;
    logic [X_BITWIDTH-1:0]    player_x;
    logic [Y_BITWIDTH-1:0]    player_y;
    logic [NUM_OBSTACLES-1:0] obs_enable;
    logic [IDX_W-1:0]         obs_index;
    logic [X_BITWIDTH-1:0]    obs_x;
    logic [Y_BITWIDTH-1:0]    obs_y;
    logic                     busy;
    logic                     done;
    logic [NUM_OBSTACLES-1:0] collision_mask;
    logic                     collision;
    modport master (
        output update, player_x, player_y, obs_enable, obs_x, obs_y,
        input  obs_index, busy, done, collision_mask, collision
    );
    modport slave (
        input  update, player_x, player_y, obs_enable, obs_x, obs_y,
        output obs_index, busy, done, collision_mask, collision
    );
endinterface

// File: rtl/collision_scheduler_rect_overlap.sv
// rect_overlap: strict axis-aligned box overlap; sums widened so edges near the coordinate limit never wrap.
module rect_overlap #(
    parameter int X_BITWIDTH      = 8,
    parameter int Y_BITWIDTH      = 8,
    parameter int PLAYER_WIDTH    = 50,
    parameter int PLAYER_HEIGHT   = 50,
    parameter int OBSTACLE_WIDTH  = 50,
    parameter int OBSTACLE_HEIGHT = 50
) (
    input  logic [X_BITWIDTH-1:0] px_i,
    input  logic [Y_BITWIDTH-1:0] py_i,
    input  logic [X_BITWIDTH-1:0] ox_i,
    input  logic [Y_BITWIDTH-1:0] oy_i,
    output logic                  hit_o
);
    localparam int XS = X_BITWIDTH + $clog2((PLAYER_WIDTH > OBSTACLE_WIDTH ? PLAYER_WIDTH : OBSTACLE_WIDTH) + 1);
    localparam int YS = Y_BITWIDTH + $clog2((PLAYER_HEIGHT > OBSTACLE_HEIGHT ? PLAYER_HEIGHT : OBSTACLE_HEIGHT) + 1);
    logic [XS-1:0] px, ox;
    logic [YS-1:0] py, oy;
    assign px = XS'(px_i);
    assign ox = XS'(ox_i);
    assign py = YS'(py_i);
    assign oy = YS'(oy_i);
    assign hit_o = (px < ox + XS'(OBSTACLE_WIDTH)) && (px + XS'(PLAYER_WIDTH) > ox) &&
                   (py < oy + YS'(OBSTACLE_HEIGHT)) && (py + YS'(PLAYER_HEIGHT) > oy);
endmodule

// File: rtl/collision_scheduler.sv
// collision_scheduler: walks every obstacle slot through one shared overlap test per update strobe
// and publishes a per-obstacle hit mask with fixed latency.
module collision_scheduler
    import collision_scheduler_pkg::*;
#(
    parameter int X_BITWIDTH      = 8,
    parameter int Y_BITWIDTH      = 8,
    parameter int NUM_OBSTACLES   = 4,
    parameter int PLAYER_WIDTH    = DEF_PLAYER_WIDTH,
    parameter int PLAYER_HEIGHT   = DEF_PLAYER_HEIGHT,
    parameter int OBSTACLE_WIDTH  = DEF_OBSTACLE_WIDTH,
    parameter int OBSTACLE_HEIGHT = DEF_OBSTACLE_HEIGHT
) (
    input logic clock,
    input logic reset,
    collision_scheduler_if.slave bus
);
    localparam int IDX_W = idx_w(NUM_OBSTACLES);
    localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_OBSTACLES - 1);

    state_e                   state_q, state_d;
    logic [IDX_W-1:0]         idx_q, idx_d;
    logic [X_BITWIDTH-1:0]    px_q, px_d;
    logic [Y_BITWIDTH-1:0]    py_q, py_d;
    logic [NUM_OBSTACLES-1:0] en_q, en_d;
    logic [NUM_OBSTACLES-1:0] work_q, work_d;
    logic [NUM_OBSTACLES-1:0] mask_q, mask_d;
    logic                     coll_q, coll_d;
    logic                     hit;

    rect_overlap #(
        .X_BITWIDTH(X_BITWIDTH), .Y_BITWIDTH(Y_BITWIDTH),
        .PLAYER_WIDTH(PLAYER_WIDTH), .PLAYER_HEIGHT(PLAYER_HEIGHT),
        .OBSTACLE_WIDTH(OBSTACLE_WIDTH), .OBSTACLE_HEIGHT(OBSTACLE_HEIGHT)
    ) u_overlap (
        .px_i(px_q), .py_i(py_q), .ox_i(bus.obs_x), .oy_i(bus.obs_y), .hit_o(hit)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            idx_q   <= '0;
            px_q    <= '0;
            py_q    <= '0;
            en_q    <= '0;
            work_q  <= '0;
            mask_q  <= '0;
            coll_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            px_q    <= px_d;
            py_q    <= py_d;
            en_q    <= en_d;
            work_q  <= work_d;
            mask_q  <= mask_d;
            coll_q  <= coll_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        px_d    = px_q;
        py_d    = py_q;
        en_d    = en_q;
        work_d  = work_q;
        mask_d  = mask_q;
        coll_d  = coll_q;
        case (state_q)
            IDLE: if (bus.update) begin
                px_d    = bus.player_x;
                py_d    = bus.player_y;
                en_d    = bus.obs_enable;
                work_d  = '0;
                idx_d   = '0;
                state_d = FETCH;
            end
            FETCH: state_d = COMPARE;
            COMPARE: begin
                work_d[idx_q] = hit & en_q[idx_q];
                // Results load on the same edge that enters DONE, so the last bit is taken from work_d.
                if (idx_q == LAST) begin
                    mask_d  = work_d;
                    coll_d  = |work_d;
                    idx_d   = '0;
                    state_d = DONE;
                end else begin
                    idx_d   = idx_q + 1'b1;
                    state_d = FETCH;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.busy           = (state_q != IDLE);
        bus.done           = (state_q == DONE);
        bus.obs_index      = idx_q;
        bus.collision_mask = mask_q;
        bus.collision      = coll_q;
    end
endmodule

// File: tb/tb_collision_scheduler.sv
// tb_collision_scheduler: directed scans against a scoreboard of model-predicted masks and done cycles.
module tb_collision_scheduler;
    localparam int N = 4;

    typedef struct {
        logic [N-1:0] mask;
        int           cyc;
    } exp_t;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    collision_scheduler_if #(.X_BITWIDTH(8), .Y_BITWIDTH(8), .NUM_OBSTACLES(N)) bus ();
    collision_scheduler #(.NUM_OBSTACLES(N)) dut (.clock(clock), .reset(reset), .bus(bus));

    logic [7:0] ox [N];
    logic [7:0] oy [N];
    always @(posedge clock) begin
        bus.obs_x <= ox[bus.obs_index];
        bus.obs_y <= oy[bus.obs_index];
    end

    int ec = 0;
    always @(posedge clock) ec <= ec + 1;

    exp_t         sb[$];
    int           checks = 0;
    int           passed = 0;
    int           dones = 0;
    logic [N-1:0] last_mask = '0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    endtask

    function automatic bit ovl(input int px, input int py, input int qx, input int qy);
        return (px < qx + 50) && (px + 50 > qx) && (py < qy + 50) && (py + 50 > qy);
    endfunction

    always @(negedge clock) begin
        if (bus.done === 1'b1) begin
            exp_t e;
            dones++;
            chk("done_expected", 32'(sb.size() != 0), 1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("mask", 32'(bus.collision_mask), 32'(e.mask));
                chk("collision", 32'(bus.collision), 32'(|e.mask));
                chk("done_cycle", ec, e.cyc);
                last_mask = e.mask;
            end
        end
    end

    task automatic set_obs(input int i, input int x, input int y);
        ox[i] = 8'(x);
        oy[i] = 8'(y);
    endtask

    // Leaves the caller at the falling edge of cycle 1 (update sampled at edge 0).
    task automatic start(input int px, input int py, input logic [N-1:0] en);
        exp_t e;
        @(negedge clock);
        bus.player_x   = 8'(px);
        bus.player_y   = 8'(py);
        bus.obs_enable = en;
        bus.update     = 1'b1;
        for (int i = 0; i < N; i++) e.mask[i] = en[i] && ovl(px, py, int'(ox[i]), int'(oy[i]));
        e.cyc = ec + 2 * N + 1;
        sb.push_back(e);
        @(negedge clock);
        bus.update = 1'b0;
    endtask

    task automatic wait_done();
        repeat (2 * N + 4) @(negedge clock);
        #1;
        chk("scan_complete", sb.size(), 0);
        chk("busy_after", 32'(bus.busy), 0);
        chk("mask_hold", 32'(bus.collision_mask), 32'(last_mask));
    endtask

    initial begin
        int d0;
        bus.update = 1'b0;
        bus.player_x = '0;
        bus.player_y = '0;
        bus.obs_enable = '0;
        for (int i = 0; i < N; i++) set_obs(i, 0, 0);
        repeat (2) @(negedge clock);
        chk("rst_busy", 32'(bus.busy), 0);
        chk("rst_done", 32'(bus.done), 0);
        chk("rst_mask", 32'(bus.collision_mask), 0);
        chk("rst_collision", 32'(bus.collision), 0);
        chk("rst_index", 32'(bus.obs_index), 0);
        reset = 1'b0;

        set_obs(0, 120, 130);
        start(100, 100, 4'b0001);
        chk("busy_fetch", 32'(bus.busy), 1);
        chk("index_first", 32'(bus.obs_index), 0);
        bus.player_x = 8'd0;
        bus.player_y = 8'd0;
        repeat (2) @(negedge clock);
        chk("index_second", 32'(bus.obs_index), 1);
        wait_done();
        chk("index_idle", 32'(bus.obs_index), 0);

        set_obs(0, 0, 0);
        set_obs(1, 150, 100);
        start(100, 100, 4'b1111);
        wait_done();

        set_obs(1, 0, 0);
        set_obs(2, 200, 100);
        start(240, 100, 4'b0100);
        wait_done();

        for (int i = 0; i < N; i++) set_obs(i, 90 + 10 * i, 110);
        start(100, 100, 4'b1010);
        wait_done();

        d0 = dones;
        start(100, 100, 4'b1111);
        repeat (2) @(negedge clock);
        bus.player_x = 8'd0;
        bus.update = 1'b1;
        @(negedge clock);
        bus.update = 1'b0;
        wait_done();
        repeat (2 * N + 2) @(negedge clock);
        chk("single_done", dones - d0, 1);

        d0 = dones;
        set_obs(0, 0, 0);
        start(100, 100, 4'b1111);
        repeat (4) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        void'(sb.pop_back());
        chk("rst_mid_busy", 32'(bus.busy), 0);
        chk("rst_mid_mask", 32'(bus.collision_mask), 0);
        chk("rst_mid_collision", 32'(bus.collision), 0);
        repeat (2 * N + 4) @(negedge clock);
        chk("rst_mid_no_done", dones - d0, 0);
        last_mask = '0;

        start(130, 105, 4'b0111);
        wait_done();

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
